// File: rtl/rv_mini_core.sv
// Single-cycle RV32 core for ADDI/ADD/BEQ/JAL: PC, immediate generator, 32x32 register file, ALU, control.
// Optional build macro RV_MINI_ILLEGAL_TRAP_EN: flag unsupported encodings and hold the PC on them.
module rv_mini_core #(
  parameter int DATA_WIDTH = 32,
  parameter int DIR_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [DATA_WIDTH-1:0] instruction,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic                  rf_we,
  output logic [DIR_WIDTH-1:0]  rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  illegal_instr
);

  localparam int NREG = 1 << DIR_WIDTH;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_ADD  = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  logic [6:0]           opcode;
  logic [6:0]           funct7;
  logic [2:0]           funct3;
  logic [DIR_WIDTH-1:0] rd, rs1, rs2;

  assign opcode = instruction[6:0];
  assign rd     = instruction[7 +: DIR_WIDTH];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[15 +: DIR_WIDTH];
  assign rs2    = instruction[20 +: DIR_WIDTH];
  assign funct7 = instruction[31:25];

  logic signed [DATA_WIDTH-1:0] imm_i, imm_b, imm_j;

  assign imm_i = {{(DATA_WIDTH-12){instruction[31]}}, instruction[31:20]};
  assign imm_b = {{(DATA_WIDTH-13){instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_j = {{(DATA_WIDTH-21){instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};

  logic is_addi, is_add, is_beq, is_jal;

  always_comb begin
    is_addi = 1'b0;
    is_add  = 1'b0;
    is_beq  = 1'b0;
    is_jal  = 1'b0;
    case (opcode)
      OP_ADDI: is_addi = (funct3 == 3'b000);
      OP_ADD:  is_add  = (funct3 == 3'b000) && (funct7 == 7'b0000000);
      OP_BEQ:  is_beq  = (funct3 == 3'b000);
      OP_JAL:  is_jal  = 1'b1;
      default: ;
    endcase
  end

  logic [DATA_WIDTH-1:0] rf_q [NREG];
  logic [DATA_WIDTH-1:0] rs1_val, rs2_val, op2;

  // x0 is hardwired: its storage is never written, but the read mux makes that explicit.
  assign rs1_val = (rs1 == '0) ? '0 : rf_q[rs1];
  assign rs2_val = (rs2 == '0) ? '0 : rf_q[rs2];

  always_comb begin
    op2 = imm_i;
    if (is_add)      op2 = rs2_val;
    else if (is_beq) op2 = imm_b;
    else if (is_jal) op2 = imm_j;
  end

  assign alu_result = rs1_val + op2;

  logic [DATA_WIDTH-1:0] pc_q, pc_d, pc_plus4;
  logic                  br_taken;

  assign pc       = pc_q;
  assign pc_plus4 = pc_q + DATA_WIDTH'(4);
  assign br_taken = is_beq && (rs1_val == rs2_val);

  always_comb begin
    pc_d = pc_plus4;
    if (is_jal)        pc_d = pc_q + imm_j;
    else if (br_taken) pc_d = pc_q + imm_b;
`ifdef RV_MINI_ILLEGAL_TRAP_EN
    if (!(is_addi || is_add || is_beq || is_jal)) pc_d = pc_q;
`endif
  end

`ifdef RV_MINI_ILLEGAL_TRAP_EN
  assign illegal_instr = arst_n & ~(is_addi | is_add | is_beq | is_jal);
`else
  assign illegal_instr = 1'b0;
`endif

  assign rf_we    = is_addi | is_add | is_jal;
  assign rf_waddr = rd;
  assign rf_wdata = is_jal ? pc_plus4 : alu_result;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Reads above see the pre-edge contents, so a same-cycle read of rd returns the old value.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (rf_we && (rd != '0)) begin
      rf_q[rd] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_rv_mini_core.sv
// Directed bench for rv_mini_core: expected values queued per instruction, popped and asserted on output.
module tb_rv_mini_core;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [31:0] instruction = 32'h0;
  logic [31:0] pc, alu_result, rf_wdata;
  logic        rf_we, illegal_instr;
  logic [4:0]  rf_waddr;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

`ifdef RV_MINI_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  rv_mini_core #(.DATA_WIDTH(32), .DIR_WIDTH(5)) dut (
    .clk(clk), .arst_n(arst_n), .instruction(instruction), .pc(pc),
    .alu_result(alu_result), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] enc_addi(int rd, int rs1, int imm);
    logic [11:0] i12 = 12'(imm);
    return {i12, 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_add(int rd, int rs1, int rs2, logic [6:0] f7);
    return {f7, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_beq(int rs1, int rs2, int imm);
    logic [12:0] b = 13'(imm);
    return {b[12], b[10:5], 5'(rs2), 5'(rs1), 3'b000, b[4:1], b[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_jal(int rd, int imm);
    logic [20:0] j = 21'(imm);
    return {j[20], j[10:1], j[11], j[19:12], 5'(rd), 7'b1101111};
  endfunction

  task automatic push(string tag, logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic chk(logic [31:0] obs);
    string       t;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard: observed %h with empty queue, expected a queued value", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", t, obs, e);
      end
    end
  endtask

  // Called just after a falling edge: drives one instruction, checks the cycle's outputs, then the new PC.
  task automatic exec(string tag, logic [31:0] instr, bit chk_alu, logic [31:0] alu,
                      logic we, logic [4:0] waddr, logic [31:0] wdata, logic ill,
                      logic [31:0] pc_next);
    if (chk_alu) push({tag, ".alu"}, alu);
    push({tag, ".we"}, {31'b0, we});
    push({tag, ".waddr"}, {27'b0, waddr});
    if (we) push({tag, ".wdata"}, wdata);
    push({tag, ".ill"}, {31'b0, ill});
    push({tag, ".pc"}, pc_next);
    instruction = instr;
    #1;
    if (chk_alu) chk(alu_result);
    chk({31'b0, rf_we});
    chk({27'b0, rf_waddr});
    if (we) chk(rf_wdata);
    chk({31'b0, illegal_instr});
    @(posedge clk); #1;
    chk(pc);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] p;
    // Reset held: nothing commits across an edge.
    instruction = enc_addi(5, 0, 7);
    push("rst.pc", 32'h0);
    push("rst.ill", 32'h0);
    #1;
    chk(pc);
    chk({31'b0, illegal_instr});
    @(posedge clk); #1;
    push("rst.pc_hold", 32'h0);
    chk(pc);
    @(negedge clk);
    arst_n = 1'b1;

    exec("addi_x5",   32'h00700293,                       1, 32'd7,        1, 5,  32'd7,    0, 32'd4);
    exec("addi_x6",   enc_addi(6, 0, -3),                 1, 32'hFFFFFFFD, 1, 6,  32'hFFFFFFFD, 0, 32'd8);
    exec("beq_taken", enc_beq(1, 1, 16),                  0, 32'h0,        0, 5'(16 & 5'h1f) /*imm bits*/, 32'h0, 0, 32'd24);
    exec("add_x7",    enc_add(7, 5, 6, 7'b0),             1, 32'd4,        1, 7,  32'd4,    0, 32'd28);
    exec("add_x0",    enc_add(0, 5, 6, 7'b0),             1, 32'd4,        1, 0,  32'd4,    0, 32'd32);
    exec("rd_x0",     enc_addi(0, 0, 0),                  1, 32'd0,        1, 0,  32'd0,    0, 32'd36);
    exec("rd_x7",     enc_addi(0, 7, 0),                  1, 32'd4,        1, 0,  32'd4,    0, 32'd40);
    exec("beq_nt",    enc_beq(5, 6, -8),                  0, 32'h0,        0, 5'b11001, 32'h0, 0, 32'd44);
    exec("beq_neg",   enc_beq(0, 0, -8),                  0, 32'h0,        0, 5'b11001, 32'h0, 0, 32'd36);
    exec("jal_x1",    enc_jal(1, 2048),                   0, 32'h0,        1, 1,  32'd40,   0, 32'd2084);
    exec("jal_x0",    enc_jal(0, -4),                     0, 32'h0,        1, 0,  32'd2088, 0, 32'd2080);
    exec("rd_x1",     enc_addi(0, 1, 0),                  1, 32'd40,       1, 0,  32'd40,   0, 32'd2084);
    exec("jal_top",   enc_jal(0, -2088),                  0, 32'h0,        1, 0,  32'd2088, 0, 32'hFFFFFFFC);
    exec("pc_wrap",   enc_addi(8, 0, -1),                 1, 32'hFFFFFFFF, 1, 8,  32'hFFFFFFFF, 0, 32'd0);
    exec("addi_7ff",  enc_addi(9, 8, 12'h7FF),            1, 32'h000007FE, 1, 9,  32'h000007FE, 0, 32'd4);
    exec("rd_x9",     enc_addi(0, 9, 0),                  1, 32'h000007FE, 1, 0,  32'h000007FE, 0, 32'd8);
    exec("addi_old",  enc_addi(5, 5, 1),                  1, 32'd8,        1, 5,  32'd8,    0, 32'd12);
    exec("rd_x5",     enc_addi(0, 5, 0),                  1, 32'd8,        1, 0,  32'd8,    0, 32'd16);
    p = TRAP ? 32'd16 : 32'd20;
    exec("bad_f7",    enc_add(10, 5, 6, 7'b0100000),      0, 32'h0,        0, 10, 32'h0,    TRAP, p);
    exec("bad_op",    32'h00000000,                       0, 32'h0,        0, 0,  32'h0,    TRAP, p + (TRAP ? 32'd0 : 32'd4));
    p = p + (TRAP ? 32'd0 : 32'd4);
    exec("rd_x10",    enc_addi(0, 10, 0),                 1, 32'd0,        1, 0,  32'd0,    0, p + 32'd4);

    // Mid-cycle reset: PC and registers clear at once, without waiting for a clock edge.
    instruction = enc_addi(0, 5, 0);
    push("mid.alu_pre", 32'd8);
    #1;
    chk(alu_result);
    #1;
    arst_n = 1'b0;
    #1;
    push("mid.pc", 32'h0);
    push("mid.alu", 32'h0);
    push("mid.ill", 32'h0);
    chk(pc);
    chk(alu_result);
    chk({31'b0, illegal_instr});
    @(posedge clk); #1;
    push("mid.pc_hold", 32'h0);
    chk(pc);
    @(negedge clk);
    arst_n = 1'b1;
    exec("post_x7",   enc_addi(0, 7, 0),                  1, 32'd0,        1, 0,  32'd0,    0, 32'd4);
    exec("post_x1",   enc_addi(11, 1, 5),                 1, 32'd5,        1, 11, 32'd5,    0, 32'd8);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: observed %0d leftover, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
